// File: rtl/alu_seq_pkg.sv
// Shared types and opcodes for the Execute-stage multicycle MUL/MOD sequencer.
// Optional feature macro used by this block: MULSEQ_EARLY_EXIT_EN.
package alu_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

   typedef enum logic {SEQ_MUL, SEQ_MOD} seq_op_t;

   localparam logic [3:0] OP_MUL = 4'b1110;
   localparam logic [3:0] OP_MOD = 4'b0110;

endpackage

// File: rtl/mulmod_datapath.sv
// Iterative datapath: unsigned shift-add multiply and restoring-division remainder.
// One iteration per asserted step; load captures operands and the operation.
module mulmod_datapath
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  seq_op_t          op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] result,
   output logic             mplier_zero
);

   seq_op_t          op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   rem_sub;

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q      <= SEQ_MUL;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         divisor_q <= '0;
         a_q       <= '0;
      end else begin
         op_q      <= op_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         divisor_q <= divisor_d;
         a_q       <= a_d;
      end
   end

   always_comb begin
      op_d      = op_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      divisor_d = divisor_q;
      a_d       = a_q;
      // Trial remainder is one bit wider so the compare never overflows.
      rem_shift = {rem_q, dvd_q[WIDTH-1]};
      rem_sub   = rem_shift - {1'b0, divisor_q};
      if (load) begin
         op_d      = op;
         acc_d     = '0;
         mcand_d   = src_a;
         mplier_d  = src_b;
         rem_d     = '0;
         dvd_d     = src_a;
         divisor_d = src_b;
         a_d       = src_a;
      end else if (step) begin
         if (op_q == SEQ_MUL) begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
         end else begin
            if (rem_shift >= {1'b0, divisor_q}) begin
               rem_d = rem_sub[WIDTH-1:0];
            end else begin
               rem_d = rem_shift[WIDTH-1:0];
            end
            dvd_d = dvd_q << 1;
         end
      end
   end

   always_comb begin
      if (op_q == SEQ_MUL) begin
         result = acc_q;
      end else if (divisor_q == '0) begin
         result = a_q;
      end else begin
         result = rem_q;
      end
   end

   // True when the multiplier is exhausted once the current iteration completes.
   assign mplier_zero = (op_q == SEQ_MUL) && (mplier_q[WIDTH-1:1] == '0);

endmodule

// File: rtl/multicycle_alu_sequencer.sv
// Execute-stage sequencer for iterative MUL/MOD: stalls F/D/E while iterating, then presents the result.
// Optional feature macro: MULSEQ_EARLY_EXIT_EN (MUL finishes once the multiplier is exhausted).
module multicycle_alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned OPCODEWIDTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   validE,
   input  logic                   flushE,
   input  logic [OPCODEWIDTH-1:0] opcodeE,
   input  logic [WIDTH-1:0]       srcAE,
   input  logic [WIDTH-1:0]       srcBE,
   output logic                   stallE,
   output logic                   resultValidE,
   output logic [WIDTH-1:0]       resultE
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             is_mul;
   logic             is_mod;
   logic             start;
   logic             dp_load;
   logic             dp_step;
   logic             mplier_zero;
   seq_op_t          dp_op;
   logic [WIDTH-1:0] dp_result;

   assign is_mul = (opcodeE == OPCODEWIDTH'(OP_MUL));
   assign is_mod = (opcodeE == OPCODEWIDTH'(OP_MOD));
   assign start  = validE & ~flushE & (is_mul | is_mod);
   assign dp_op  = is_mul ? SEQ_MUL : SEQ_MOD;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               count_d = '0;
            end
         end
         RUN: begin
            if (flushE) begin
               state_d = IDLE;
            end else begin
               count_d = count_q + CNT_W'(1);
               if (count_q == LAST_COUNT) begin
                  state_d = DONE;
               end
`ifdef MULSEQ_EARLY_EXIT_EN
               if (mplier_zero) begin
                  state_d = DONE;
               end
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifndef MULSEQ_EARLY_EXIT_EN
   logic unused_mplier_zero;
   assign unused_mplier_zero = mplier_zero;
`endif

   always_comb begin
      stallE       = 1'b0;
      resultValidE = 1'b0;
      dp_load      = 1'b0;
      dp_step      = 1'b0;
      case (state_q)
         IDLE: begin
            stallE  = start;
            dp_load = start;
         end
         RUN: begin
            stallE  = ~flushE;
            dp_step = ~flushE;
         end
         DONE:    resultValidE = ~flushE;
         default: stallE = 1'b0;
      endcase
   end

   mulmod_datapath #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .clk        (clk),
      .reset      (reset),
      .load       (dp_load),
      .step       (dp_step),
      .op         (dp_op),
      .src_a      (srcAE),
      .src_b      (srcBE),
      .result     (dp_result),
      .mplier_zero(mplier_zero)
   );

   assign resultE = dp_result;

endmodule

// File: tb/tb_multicycle_alu_sequencer.sv
// Scoreboard bench for multicycle_alu_sequencer: driver queues expected results, negedge monitor checks them.
// Expected stall counts follow MULSEQ_EARLY_EXIT_EN when it is defined.
module tb_multicycle_alu_sequencer;

   localparam int unsigned W = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          validE;
   logic          flushE;
   logic [3:0]    opcodeE;
   logic [W-1:0]  srcAE;
   logic [W-1:0]  srcBE;
   logic          stallE;
   logic          resultValidE;
   logic [W-1:0]  resultE;

   int n_tests = 0;
   int n_fail  = 0;
   int stall_cnt = 0;
   logic [W-1:0] exp_res_q[$];
   int           exp_stall_q[$];

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   multicycle_alu_sequencer #(
      .WIDTH(W),
      .OPCODEWIDTH(4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .validE      (validE),
      .flushE      (flushE),
      .opcodeE     (opcodeE),
      .srcAE       (srcAE),
      .srcBE       (srcBE),
      .stallE      (stallE),
      .resultValidE(resultValidE),
      .resultE     (resultE)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_stall(input logic [3:0] op, input logic [W-1:0] b);
`ifdef MULSEQ_EARLY_EXIT_EN
      if (op == 4'b1110) begin
         int n = 1;
         for (int i = 1; i < W; i++) if (b[i]) n = i + 1;
         return n + 1;
      end
`endif
      return W + 1;
   endfunction

   // Monitor: pops one expectation per resultValidE pulse.
   always @(negedge clk) begin
      if (reset) begin
         stall_cnt = 0;
      end else if (resultValidE) begin
         if (exp_res_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            check("result", 32'(resultE), 32'(exp_res_q.pop_front()));
            check("stall_cycles", stall_cnt, exp_stall_q.pop_front());
         end
         stall_cnt = 0;
      end else if (stallE) begin
         stall_cnt++;
      end else begin
         stall_cnt = 0;
      end
   end

   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r);
      bit seen = 1'b0;
      exp_res_q.push_back(r);
      exp_stall_q.push_back(exp_stall(op, b));
      @(posedge clk); #1;
      validE = 1'b1; flushE = 1'b0; opcodeE = op; srcAE = a; srcBE = b;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (resultValidE) seen = 1'b1;
      end
      if (!seen) begin
         check("result_timeout", 32'd0, 32'd1);
         exp_res_q.delete();
         exp_stall_q.delete();
      end
   endtask

   task automatic quiet(input int n, input logic [W-1:0] hold);
      repeat (n) begin
         @(negedge clk);
         check("quiet_stall", 32'(stallE), 32'd0);
         check("quiet_valid", 32'(resultValidE), 32'd0);
         check("quiet_result_hold", 32'(resultE), 32'(hold));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{4'b1110, 16'd7,     16'd6,     16'd42};
      vecs[1] = '{4'b0110, 16'd100,   16'd7,     16'd2};
      vecs[2] = '{4'b0110, 16'd25,    16'd0,     16'd25};
      vecs[3] = '{4'b1110, 16'hFFFF,  16'hFFFF,  16'h0001};
      vecs[4] = '{4'b1110, 16'd300,   16'd300,   16'h5F90};
      vecs[5] = '{4'b0110, 16'hFFFF,  16'h00FF,  16'h0000};
      vecs[6] = '{4'b0110, 16'd5,     16'd9,     16'd5};
      vecs[7] = '{4'b1110, 16'h1234,  16'h0010,  16'h2340};
      vecs[8] = '{4'b1110, 16'd5,     16'd0,     16'd0};
      vecs[9] = '{4'b1110, 16'd3,     16'd2,     16'd6};

      reset = 1'b1; validE = 1'b0; flushE = 1'b0; opcodeE = '0; srcAE = '0; srcBE = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_stall", 32'(stallE), 32'd0);
      check("reset_valid", 32'(resultValidE), 32'd0);
      check("reset_result", 32'(resultE), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Consecutive run_op calls issue the next op right after DONE.
      foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r);
      @(posedge clk); #1;
      validE = 1'b0; opcodeE = '0;
      quiet(2, 16'd6);

      // Single-cycle opcodes: no stall, last result held.
      foreach (vecs[i]) if (i < 3) begin
         logic [3:0] pass_ops [3];
         pass_ops = '{4'b0101, 4'b1010, 4'b0000};
         @(posedge clk); #1;
         validE = 1'b1; opcodeE = pass_ops[i]; srcAE = 16'd9; srcBE = 16'd4;
         quiet(2, 16'd6);
      end

      @(posedge clk); #1;
      validE = 1'b0; opcodeE = 4'b1110;
      quiet(2, 16'd6);

      @(posedge clk); #1;
      validE = 1'b1; flushE = 1'b1; opcodeE = 4'b0110;
      quiet(2, 16'd6);

      // Flush during RUN cycle 5.
      @(posedge clk); #1;
      validE = 1'b1; flushE = 1'b0; opcodeE = 4'b1110; srcAE = 16'd7; srcBE = 16'd6;
      @(negedge clk);
      check("start_stall", 32'(stallE), 32'd1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("run_stall", 32'(stallE), 32'd1);
      @(posedge clk); #1;
      flushE = 1'b1;
      @(negedge clk);
      check("flush_stall_drop", 32'(stallE), 32'd0);
      check("flush_no_valid", 32'(resultValidE), 32'd0);
      @(posedge clk); #1;
      flushE = 1'b0; validE = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("post_flush_stall", 32'(stallE), 32'd0);
         check("post_flush_valid", 32'(resultValidE), 32'd0);
      end

      // Reset in RUN with a partial product already accumulated.
      @(posedge clk); #1;
      validE = 1'b1; opcodeE = 4'b1110; srcAE = 16'd7; srcBE = 16'd6;
      repeat (3) @(posedge clk);
      #1;
      check("run_before_reset", 32'(stallE), 32'd1);
      reset = 1'b1; validE = 1'b0;
      @(posedge clk); #1;
      check("mid_reset_stall", 32'(stallE), 32'd0);
      check("mid_reset_valid", 32'(resultValidE), 32'd0);
      check("mid_reset_result", 32'(resultE), 32'd0);
      reset = 1'b0;
      quiet(3, 16'd0);

      // Operation after mid-run reset still completes normally.
      run_op(4'b0110, 16'd1000, 16'd7, 16'd6);
      @(posedge clk); #1;
      validE = 1'b0;
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_res_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
